dmem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer for the single-port data memory.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory.
// Each grant is one SERVE cycle. Read data and Done return registered on the edge that ends it.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        A_Req,
  input  logic        A_We,
  input  logic [31:0] A_Addr,
  input  logic [31:0] A_WData,
  output logic        A_Done,
  output logic        A_Err,
  output logic [31:0] A_RData,
  input  logic        B_Req,
  input  logic        B_We,
  input  logic [31:0] B_Addr,
  input  logic [31:0] B_WData,
  output logic        B_Done,
  output logic        B_Err,
  output logic [31:0] B_RData,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic        Mem_WriteEn,
  output logic        Mem_ReadEn,
  input  logic [31:0] Mem_ReadData,
  output logic        Busy,
  output logic        GntB
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic {StIdle, StServe} stateE;

  stateE           state;
  logic            rrFavB;
  logic [CntW-1:0] waitCnt;
  logic            wePend;
  logic            errPend;

  logic        anyReq;
  logic        pickB;
  logic        selWe;
  logic        selOor;
  logic [31:0] selAddr;
  logic [31:0] selWData;
  logic [31:0] serveData;

  always_comb begin
    anyReq = A_Req | B_Req;
    if (ARB_MODE == 0) begin
      pickB = B_Req & (~A_Req | rrFavB);
    end else begin
      pickB = B_Req & (~A_Req | (waitCnt == CntW'(MAX_WAIT)));
    end
    selWe     = pickB ? B_We : A_We;
    selAddr   = pickB ? B_Addr : A_Addr;
    selWData  = pickB ? B_WData : A_WData;
    selOor    = (selAddr >= DEPTH);
    // Writes and rejected accesses return zero read data.
    serveData = (errPend | wePend) ? 32'h0 : Mem_ReadData;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= StIdle;
      rrFavB        <= 1'b0;
      waitCnt       <= '0;
      wePend        <= 1'b0;
      errPend       <= 1'b0;
      A_Done        <= 1'b0;
      A_Err         <= 1'b0;
      A_RData       <= 32'h0;
      B_Done        <= 1'b0;
      B_Err         <= 1'b0;
      B_RData       <= 32'h0;
      Mem_Address   <= 32'h0;
      Mem_WriteData <= 32'h0;
      Mem_WriteEn   <= 1'b0;
      Mem_ReadEn    <= 1'b0;
      Busy          <= 1'b0;
      GntB          <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          A_Done <= 1'b0;
          A_Err  <= 1'b0;
          B_Done <= 1'b0;
          B_Err  <= 1'b0;
          GntB   <= pickB;
          // Starvation guard counts only edges where B asks and A takes the grant.
          if (!B_Req || pickB) begin
            waitCnt <= '0;
          end else if (waitCnt != CntW'(MAX_WAIT)) begin
            waitCnt <= waitCnt + CntW'(1);
          end
          if (anyReq) begin
            state         <= StServe;
            Busy          <= 1'b1;
            rrFavB        <= ~pickB;
            wePend        <= selWe;
            errPend       <= selOor;
            Mem_Address   <= selOor ? 32'h0 : selAddr;
            Mem_WriteData <= selOor ? 32'h0 : selWData;
            Mem_WriteEn   <= ~selOor & selWe;
            Mem_ReadEn    <= ~selOor & ~selWe;
          end
        end
        StServe: begin
          state         <= StIdle;
          Busy          <= 1'b0;
          GntB          <= 1'b0;
          Mem_Address   <= 32'h0;
          Mem_WriteData <= 32'h0;
          Mem_WriteEn   <= 1'b0;
          Mem_ReadEn    <= 1'b0;
          if (GntB) begin
            B_Done  <= 1'b1;
            B_Err   <= errPend;
            B_RData <= serveData;
          end else begin
            A_Done  <= 1'b1;
            A_Err   <= errPend;
            A_RData <= serveData;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance with a memory model,
// plus a fixed-priority instance (MAX_WAIT=2) used for the starvation-guard order.
module tb_dmem_arbiter;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  logic        aReq, bReq, aWe, bWe;
  logic [31:0] aAddr, bAddr, aWData, bWData;

  logic        aDone0, bDone0, aErr0, bErr0, memWe0, memRe0, busy0, gntB0;
  logic [31:0] aRData0, bRData0, memAddr0, memWData0, memRData0;
  logic        aDone1, bDone1, aErr1, bErr1, memWe1, memRe1, busy1, gntB1;
  logic [31:0] aRData1, bRData1, memAddr1, memWData1, memRData1;

  logic [31:0] mem [0:31];

  always @(negedge Clock) if (memWe0) mem[memAddr0[4:0]] <= memWData0;
  assign memRData0 = memRe0 ? mem[memAddr0[4:0]] : 32'h0;
  assign memRData1 = 32'h0;

  dmem_arbiter #(.DEPTH(32), .ARB_MODE(0), .MAX_WAIT(4)) dutRr (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_Req(aReq), .A_We(aWe), .A_Addr(aAddr), .A_WData(aWData),
    .A_Done(aDone0), .A_Err(aErr0), .A_RData(aRData0),
    .B_Req(bReq), .B_We(bWe), .B_Addr(bAddr), .B_WData(bWData),
    .B_Done(bDone0), .B_Err(bErr0), .B_RData(bRData0),
    .Mem_Address(memAddr0), .Mem_WriteData(memWData0), .Mem_WriteEn(memWe0),
    .Mem_ReadEn(memRe0), .Mem_ReadData(memRData0), .Busy(busy0), .GntB(gntB0)
  );

  dmem_arbiter #(.DEPTH(32), .ARB_MODE(1), .MAX_WAIT(2)) dutPri (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_Req(aReq), .A_We(aWe), .A_Addr(aAddr), .A_WData(aWData),
    .A_Done(aDone1), .A_Err(aErr1), .A_RData(aRData1),
    .B_Req(bReq), .B_We(bWe), .B_Addr(bAddr), .B_WData(bWData),
    .B_Done(bDone1), .B_Err(bErr1), .B_RData(bRData1),
    .Mem_Address(memAddr1), .Mem_WriteData(memWData1), .Mem_WriteEn(memWe1),
    .Mem_ReadEn(memRe1), .Mem_ReadData(memRData1), .Busy(busy1), .GntB(gntB1)
  );

  int passCnt = 0;
  int totalCnt = 0;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idleInputs;
    aReq = 0; bReq = 0; aWe = 0; bWe = 0;
    aAddr = 0; bAddr = 0; aWData = 0; bWData = 0;
  endtask

  task automatic doReset;
    idleInputs();
    Reset_n = 0;
    tick();
    Reset_n = 1;
  endtask

  task automatic test_reset;
    idleInputs();
    aReq = 1;
    Reset_n = 0;
    tick();
    tick();
    totalCnt++;
    if ({aDone0, bDone0, aErr0, bErr0, memWe0, memRe0, busy0, gntB0} !== 8'h00)
      $display("FAIL rst_flags: got %b want 00000000",
               {aDone0, bDone0, aErr0, bErr0, memWe0, memRe0, busy0, gntB0});
    else passCnt++;
    totalCnt++;
    if ({aRData0, bRData0, memAddr0, memWData0} !== 128'h0)
      $display("FAIL rst_data: got %h want 0", {aRData0, bRData0, memAddr0, memWData0});
    else passCnt++;
    totalCnt++;
    if ({busy1, gntB1, memWe1, memRe1} !== 4'h0)
      $display("FAIL rst_pri: got %b want 0000", {busy1, gntB1, memWe1, memRe1});
    else passCnt++;
    aReq = 0;
    Reset_n = 1;
  endtask

  task automatic test_write_read;
    doReset();
    aReq = 1; aWe = 1; aAddr = 5; aWData = 32'hDEADBEEF;
    tick();
    totalCnt++;
    if ({busy0, gntB0, memWe0, memRe0} !== 4'b1010)
      $display("FAIL wr_serve: got %b want 1010", {busy0, gntB0, memWe0, memRe0});
    else passCnt++;
    totalCnt++;
    if (memAddr0 !== 32'd5 || memWData0 !== 32'hDEADBEEF)
      $display("FAIL wr_bus: got %h/%h want 5/deadbeef", memAddr0, memWData0);
    else passCnt++;
    aReq = 0;
    tick();
    totalCnt++;
    if ({aDone0, aErr0, bDone0, memWe0} !== 4'b1000)
      $display("FAIL wr_done: got %b want 1000", {aDone0, aErr0, bDone0, memWe0});
    else passCnt++;
    totalCnt++;
    if (mem[5] !== 32'hDEADBEEF) $display("FAIL wr_mem: got %h want deadbeef", mem[5]);
    else passCnt++;
    aReq = 1; aWe = 0; aAddr = 5; aWData = 0;
    tick();
    totalCnt++;
    if ({memRe0, memWe0, aDone0} !== 3'b100)
      $display("FAIL rd_serve: got %b want 100", {memRe0, memWe0, aDone0});
    else passCnt++;
    aReq = 0;
    tick();
    totalCnt++;
    if (aDone0 !== 1'b1 || aErr0 !== 1'b0 || aRData0 !== 32'hDEADBEEF)
      $display("FAIL rd_done: got %b%b %h want 10 deadbeef", aDone0, aErr0, aRData0);
    else passCnt++;
    tick();
    totalCnt++;
    if (aDone0 !== 1'b0 || aRData0 !== 32'hDEADBEEF)
      $display("FAIL rd_hold: got %b %h want 0 deadbeef", aDone0, aRData0);
    else passCnt++;
  endtask

  task automatic test_round_robin;
    logic [3:0] expG;
    logic [3:0] gotG;
    int n;
    logic overlap;
    expG = 4'b1010;
    gotG = 4'b0000;
    n = 0;
    overlap = 0;
    doReset();
    aReq = 1; bReq = 1; aAddr = 5; bAddr = 5;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (aDone0 && bDone0) overlap = 1;
      if (busy0) begin
        gotG[n] = gntB0;
        n++;
      end
    end
    aReq = 0; bReq = 0;
    totalCnt++;
    if (n !== 4) $display("FAIL rr_count: got %0d want 4", n);
    else passCnt++;
    totalCnt++;
    if (gotG !== expG) $display("FAIL rr_order: got %b want %b (bit0 first)", gotG, expG);
    else passCnt++;
    tick();
    if (aDone0 && bDone0) overlap = 1;
    totalCnt++;
    if (bDone0 !== 1'b1 || bRData0 !== 32'hDEADBEEF)
      $display("FAIL rr_bdata: got %b %h want 1 deadbeef", bDone0, bRData0);
    else passCnt++;
    totalCnt++;
    if (overlap !== 1'b0) $display("FAIL rr_overlap: got %b want 0", overlap);
    else passCnt++;
    tick();
  endtask

  task automatic test_priority;
    logic [5:0] expG;
    logic [5:0] gotG;
    int n;
    expG = 6'b100100;
    gotG = 6'b000000;
    n = 0;
    doReset();
    aReq = 1; bReq = 1;
    for (int c = 0; c < 30 && n < 6; c++) begin
      tick();
      if (busy1) begin
        gotG[n] = gntB1;
        n++;
      end
    end
    aReq = 0; bReq = 0;
    totalCnt++;
    if (n !== 6) $display("FAIL pri_count: got %0d want 6", n);
    else passCnt++;
    totalCnt++;
    if (gotG !== expG) $display("FAIL pri_order: got %b want %b (bit0 first)", gotG, expG);
    else passCnt++;
    tick();
    tick();
  endtask

  task automatic test_out_of_range;
    logic enSeen;
    enSeen = 0;
    bReq = 1; bWe = 0; bAddr = 32;
    tick();
    enSeen = enSeen | memRe0 | memWe0;
    totalCnt++;
    if ({busy0, gntB0} !== 2'b11 || memAddr0 !== 32'h0)
      $display("FAIL oor_serve: got %b %h want 11 0", {busy0, gntB0}, memAddr0);
    else passCnt++;
    bReq = 0;
    tick();
    enSeen = enSeen | memRe0 | memWe0;
    totalCnt++;
    if ({bDone0, bErr0, aDone0} !== 3'b110 || bRData0 !== 32'h0)
      $display("FAIL oor_done: got %b %h want 110 0", {bDone0, bErr0, aDone0}, bRData0);
    else passCnt++;
    aReq = 1; aWe = 1; aAddr = 32'h8000_0005; aWData = 32'h1234_5678;
    tick();
    enSeen = enSeen | memRe0 | memWe0;
    aReq = 0;
    tick();
    enSeen = enSeen | memRe0 | memWe0;
    totalCnt++;
    if ({aDone0, aErr0} !== 2'b11 || mem[5] !== 32'hDEADBEEF)
      $display("FAIL oor_high: got %b %h want 11 deadbeef", {aDone0, aErr0}, mem[5]);
    else passCnt++;
    totalCnt++;
    if (enSeen !== 1'b0) $display("FAIL oor_enables: got %b want 0", enSeen);
    else passCnt++;
  endtask

  task automatic test_reset_mid_serve;
    logic doneSeen;
    doneSeen = 0;
    doReset();
    aReq = 1; aWe = 1; aAddr = 3; aWData = 32'h1111_1111;
    tick();
    aReq = 0;
    tick();
    tick();
    aReq = 1; aWe = 1; aAddr = 3; aWData = 32'hBAD0_BAD0;
    tick();
    totalCnt++;
    if (memWe0 !== 1'b1) $display("FAIL mid_pre: got %b want 1", memWe0);
    else passCnt++;
    Reset_n = 0;
    #1;
    totalCnt++;
    if ({memWe0, busy0} !== 2'b00) $display("FAIL mid_async: got %b want 00", {memWe0, busy0});
    else passCnt++;
    aReq = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      doneSeen = doneSeen | aDone0;
    end
    Reset_n = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      doneSeen = doneSeen | aDone0;
    end
    totalCnt++;
    if (mem[3] !== 32'h1111_1111) $display("FAIL mid_mem: got %h want 11111111", mem[3]);
    else passCnt++;
    totalCnt++;
    if (doneSeen !== 1'b0) $display("FAIL mid_nodone: got %b want 0", doneSeen);
    else passCnt++;
    totalCnt++;
    if ({aDone0, bDone0, aErr0, bErr0, memWe0, memRe0, busy0, gntB0} !== 8'h00 ||
        {aRData0, bRData0, memAddr0, memWData0} !== 128'h0)
      $display("FAIL mid_outs: got %b %h want 0 0",
               {aDone0, bDone0, aErr0, bErr0, memWe0, memRe0, busy0, gntB0},
               {aRData0, bRData0, memAddr0, memWData0});
    else passCnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] expBusy;
    logic [3:0] expDone;
    expBusy = 4'b0101;
    expDone = 4'b1010;
    doReset();
    aReq = 1; aWe = 0; aAddr = 5;
    for (int i = 0; i < 4; i++) begin
      tick();
      totalCnt++;
      if (busy0 !== expBusy[i] || aDone0 !== expDone[i])
        $display("FAIL b2b_cycle%0d: got busy %b done %b want %b %b",
                 i, busy0, aDone0, expBusy[i], expDone[i]);
      else passCnt++;
    end
    aReq = 0;
    tick();
    totalCnt++;
    if (aRData0 !== 32'hDEADBEEF) $display("FAIL b2b_data: got %h want deadbeef", aRData0);
    else passCnt++;
    tick();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_priority();
    test_reset_mid_serve();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
